// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: HI/LO register controller with a multicycle multiplier for MULT/MULTU/MADD/MSUB and MTHI/MTLO.
//   Clk      - clock; all state changes on the rising edge
//   Rst      - synchronous active-high reset; aborts any multiply in flight
//   Start    - request strobe; Op/A/B are sampled together with it
//   Op       - MULT 00011, MULTU 00100, MADD 10100, MSUB 10101, MTHI 11000, MTLO 11001
//   A, B     - operands (MTHI/MTLO use A only)
//   HiLoReq  - the pipeline wants to read HI/LO this cycle
//   HiLoRead - {HI,LO} register, shown directly with no bypass
//   Busy     - a multiply is in CALC or ACCUM
//   Stall    - Busy & (Start | HiLoReq), combinational
//   Done     - one-cycle pulse when HiLoRead holds a new multiply result
// Define HILO_FAST_MULT_EN to replace the ITER-cycle shift-add loop with a one-cycle full-width product.
module hilo_mult_ctrl #(
   parameter int ITER = 32
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [4:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HiLoReq,
   output logic [63:0] HiLoRead,
   output logic        Busy,
   output logic        Stall,
   output logic        Done
);
   if (ITER != 32) begin : g_bad_iter
      $error("hilo_mult_ctrl: ITER must be 32");
   end
   localparam logic [4:0] OP_MULT  = 5'b00011;
   localparam logic [4:0] OP_MULTU = 5'b00100;
   localparam logic [4:0] OP_MADD  = 5'b10100;
   localparam logic [4:0] OP_MSUB  = 5'b10101;
   localparam logic [4:0] OP_MTHI  = 5'b11000;
   localparam logic [4:0] OP_MTLO  = 5'b11001;
   typedef enum logic [1:0] {IDLE, CALC, ACCUM, DONE} state_t;
   state_t      state_q, state_d;
   logic [63:0] hilo_q, hilo_d, p_q, p_d, a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [4:0]  op_q, op_d;
   logic        neg_q, neg_d, busy_q, busy_d, done_q, done_d;
   logic        is_mul, sgn, can_start;
   logic [31:0] a_mag, b_mag;
   logic [63:0] p_fin;
`ifndef HILO_FAST_MULT_EN
   localparam logic [5:0] LAST = 6'(ITER - 1);
   logic [5:0] cnt_q, cnt_d;
`endif
   always_comb begin
      is_mul    = Op == OP_MULT || Op == OP_MULTU || Op == OP_MADD || Op == OP_MSUB;
      sgn       = Op != OP_MULTU;
      a_mag     = (sgn && A[31]) ? -A : A;
      b_mag     = (sgn && B[31]) ? -B : B;
      can_start = state_q == IDLE || state_q == DONE;
      p_fin     = neg_q ? -p_q : p_q;
      state_d   = state_q;
      hilo_d    = hilo_q;
      p_d       = p_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      neg_d     = neg_q;
`ifndef HILO_FAST_MULT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         CALC: begin
`ifdef HILO_FAST_MULT_EN
            p_d     = a_q * {32'd0, b_q};
            state_d = ACCUM;
`else
            // multiplicand walks left while the multiplier is consumed LSB first
            p_d     = b_q[0] ? p_q + a_q : p_q;
            a_d     = a_q << 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + 6'd1;
            state_d = cnt_q == LAST ? ACCUM : CALC;
`endif
         end
         ACCUM: begin
            hilo_d  = op_q == OP_MADD ? hilo_q + p_fin : op_q == OP_MSUB ? hilo_q - p_fin : p_fin;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: ;
      endcase
      // a new Start in DONE overrides the return to IDLE
      if (can_start && Start) begin
         if (is_mul) begin
            state_d = CALC;
            a_d     = {32'd0, a_mag};
            b_d     = b_mag;
            op_d    = Op;
            neg_d   = sgn & (A[31] ^ B[31]);
            p_d     = '0;
`ifndef HILO_FAST_MULT_EN
            cnt_d   = '0;
`endif
         end else if (Op == OP_MTHI) begin
            hilo_d[63:32] = A;
         end else if (Op == OP_MTLO) begin
            hilo_d[31:0] = A;
         end
      end
      busy_d = state_d == CALC || state_d == ACCUM;
      done_d = state_d == DONE;
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         hilo_q  <= '0;
         p_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifndef HILO_FAST_MULT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         hilo_q  <= hilo_d;
         p_q     <= p_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifndef HILO_FAST_MULT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end
   assign HiLoRead = hilo_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Stall    = busy_q & (Start | HiLoReq);
endmodule
